// File: rtl/proc_control_pkg.sv
// Shared definitions for the multicycle processor control unit and its datapath:
// instruction field positions, opcodes, ALU op codes and control-step encoding.
package proc_control_pkg;

  // Instruction field positions
  localparam int unsigned OP_HI = 15;
  localparam int unsigned OP_LO = 12;
  localparam int unsigned RX_HI = 11;
  localparam int unsigned RX_LO = 9;
  localparam int unsigned RY_HI = 8;
  localparam int unsigned RY_LO = 6;

  // Opcodes (1001-1111 are illegal and execute as a NOP)
  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_MVNZ = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;

  // ALU op codes, also decoded by the datapath ALU
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_IDLE = 3'b000;

  // Control steps
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  // True for opcodes that take the three-step A/G path through the ALU
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_SLT) || (op == OP_SLL) || (op == OP_SRL);
  endfunction

  // ALU code for an ALU opcode; idle code for everything else
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    logic [2:0] code;
    code = ALU_IDLE;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_SLT:  code = ALU_SLT;
      OP_SLL:  code = ALU_SLL;
      OP_SRL:  code = ALU_SRL;
      default: code = ALU_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled, so the
// result is never multi-hot.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  // Single bit set at the selected position only while enabled
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/proc_control.sv
// Multicycle control unit for the 16-bit simple processor.
//
// state | meaning
// T0    | idle / fetch: latch DIN into IR when Run
// T1    | first execute step (whole instruction for mv/mvi/mvnz/illegal)
// T2    | ALU step: rY onto bus, G <- A op bus
// T3    | write-back: G onto bus, into rX, retire
//
// Outputs are decoded from the step and IR. While Reset is high every output is
// forced low so an aborted instruction never writes a register or retires.
module proc_control
  import proc_control_pkg::*;
#(
  parameter int n    = 16,
  parameter int NREG = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [n-1:0]    DIN,
  input  logic            G_nz,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Gout,
  output logic            Ain,
  output logic            Gin,
  output logic [2:0]      alu_control,
  output logic            Done
);

  state_e         state_q, state_d;
  logic [n-1:0]   ir_q, ir_d;

  logic [3:0]     op;
  logic [2:0]     rx;
  logic [2:0]     ry;
  logic           rin_en;
  logic           rout_en;
  logic [2:0]     rout_sel;
  logic           unused_ir_bits;

  assign op             = ir_q[OP_HI:OP_LO];
  assign rx             = ir_q[RX_HI:RX_LO];
  assign ry             = ir_q[RY_HI:RY_LO];
  // Low instruction bits carry no meaning for this instruction set
  assign unused_ir_bits = ^ir_q[RY_LO-1:0];

  // Step and instruction registers, synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next step, IR load and control outputs
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel    = ry;
    DINout      = 1'b0;
    Gout        = 1'b0;
    Ain         = 1'b0;
    Gin         = 1'b0;
    alu_control = ALU_IDLE;
    Done        = 1'b0;

    unique case (state_q)
      T0: begin
        if (Run) begin
          ir_d    = DIN;
          state_d = T1;
        end
      end

      T1: begin
        state_d = T0;
        if (op == OP_MV) begin
          rout_en = 1'b1;
          rin_en  = 1'b1;
          Done    = 1'b1;
        end else if (op == OP_MVI) begin
          DINout  = 1'b1;
          rin_en  = 1'b1;
          Done    = 1'b1;
        end else if (op == OP_MVNZ) begin
          Done    = 1'b1;
          if (G_nz) begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
          end
        end else if (is_alu_op(op)) begin
          rout_sel = rx;
          rout_en  = 1'b1;
          Ain      = 1'b1;
          state_d  = T2;
        end else begin
          // Illegal opcode retires as a NOP
          Done    = 1'b1;
        end
      end

      T2: begin
        rout_en     = 1'b1;
        Gin         = 1'b1;
        alu_control = alu_code(op);
        state_d     = T3;
      end

      T3: begin
        Gout    = 1'b1;
        rin_en  = 1'b1;
        Done    = 1'b1;
        state_d = T0;
      end

      default: state_d = T0;
    endcase

    if (Reset) begin
      rin_en      = 1'b0;
      rout_en     = 1'b0;
      DINout      = 1'b0;
      Gout        = 1'b0;
      Ain         = 1'b0;
      Gin         = 1'b0;
      alu_control = ALU_IDLE;
      Done        = 1'b0;
    end
  end

  dec3to8 u_rin_dec (
    .en     (rin_en),
    .sel    (rx),
    .onehot (Rin)
  );

  dec3to8 u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: the driver pushes the expected output vector of every
// cycle into a scoreboard queue; a monitor pops and compares on each falling edge.
module tb_proc_control;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run   = 1'b0;
  logic [15:0] DIN   = 16'h0000;
  logic        G_nz  = 1'b0;
  logic [7:0]  Rin;
  logic [7:0]  Rout;
  logic        DINout;
  logic        Gout;
  logic        Ain;
  logic        Gin;
  logic [2:0]  alu_control;
  logic        Done;

  typedef struct {
    logic [23:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [23:0] ZERO = 24'd0;

  always #5 Clock = ~Clock;

  proc_control #(.n(16), .NREG(8)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Run         (Run),
    .DIN         (DIN),
    .G_nz        (G_nz),
    .Rin         (Rin),
    .Rout        (Rout),
    .DINout      (DINout),
    .Gout        (Gout),
    .Ain         (Ain),
    .Gin         (Gin),
    .alu_control (alu_control),
    .Done        (Done)
  );

  function automatic logic [23:0] pk(input logic [7:0] rin, input logic [7:0] rout,
                                     input logic dinout, input logic gout,
                                     input logic ain, input logic gin,
                                     input logic [2:0] alu, input logic done);
    return {rin, rout, dinout, gout, ain, gin, alu, done};
  endfunction

  // Reference: per-instruction list of execute-step outputs, straight from the
  // instruction-set rules. Returns the number of execute cycles.
  function automatic int model(input logic [15:0] ir, input logic gnz,
                               output logic [23:0] ex [3]);
    int         op;
    int         rx;
    int         ry;
    logic [7:0] hx;
    logic [7:0] hy;
    op = int'(ir[15:12]);
    rx = int'(ir[11:9]);
    ry = int'(ir[8:6]);
    hx = 8'(1) << rx;
    hy = 8'(1) << ry;
    ex[0] = ZERO;
    ex[1] = ZERO;
    ex[2] = ZERO;
    if (op == 0) begin
      ex[0] = pk(hx, hy, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      return 1;
    end
    if (op == 1) begin
      ex[0] = pk(hx, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      return 1;
    end
    if (op == 2) begin
      ex[0] = gnz ? pk(hx, hy, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1)
                  : pk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      return 1;
    end
    if (op >= 3 && op <= 8) begin
      ex[0] = pk(8'd0, hx, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
      ex[1] = pk(8'd0, hy, 1'b0, 1'b0, 1'b0, 1'b1, 3'(op - 3), 1'b0);
      ex[2] = pk(hx, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
      return 3;
    end
    ex[0] = pk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    return 1;
  endfunction

  // One clock of stimulus plus the outputs expected during that clock
  task automatic cycle(input logic rst, input logic run, input logic [15:0] din,
                       input logic gnz, input logic [23:0] ev, input string tag);
    exp_t e;
    @(posedge Clock);
    #1;
    Reset = rst;
    Run   = run;
    DIN   = din;
    G_nz  = gnz;
    e.v   = ev;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'($urandom), 1'($urandom), ZERO, "idle");
  endtask

  // Fetch one instruction and run its execute steps; Run is randomised during
  // execution and must be ignored. abort_at selects an execute step in which
  // Reset is raised (negative or past the end: no abort).
  task automatic issue(input logic [15:0] ir, input logic [15:0] imm,
                       input logic gnz, input int abort_at);
    logic [23:0] ex [3];
    int          len;
    len = model(ir, gnz, ex);
    cycle(1'b0, 1'b1, ir, 1'($urandom), ZERO, $sformatf("fetch_%h", ir));
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        cycle(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), ZERO,
              $sformatf("abort_%h_t%0d", ir, k + 1));
        return;
      end
      cycle(1'b0, 1'($urandom), (k == 0) ? imm : 16'($urandom),
            (k == 0) ? gnz : 1'($urandom), ex[k],
            $sformatf("exec_%h_t%0d", ir, k + 1));
    end
  endtask

  // Monitor: compare every cycle that has an expectation queued
  initial begin
    exp_t        e;
    logic [23:0] act;
    forever begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = pk(Rin, Rout, DINout, Gout, Ain, Gin, alu_control, Done);
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got rin=%h rout=%h dinout=%b gout=%b ain=%b gin=%b alu=%b done=%b, expected vector %h (got %h)",
                   e.tag, Rin, Rout, DINout, Gout, Ain, Gin, alu_control, Done, e.v, act);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int abort_at;
    int wait_cnt;

    cycle(1'b1, 1'b0, 16'h0000, 1'b0, ZERO, "reset0");
    cycle(1'b1, 1'b0, 16'h0000, 1'b0, ZERO, "reset1");
    idle();

    issue(16'h1200, 16'h0005, 1'b0, -1);
    issue(16'h3440, 16'h0000, 1'b0, -1);
    idle();
    issue(16'h2680, 16'h0000, 1'b0, -1);
    issue(16'h2680, 16'h0000, 1'b1, -1);
    for (int op = 4; op <= 8; op++) begin
      issue({4'(op), 3'd5, 3'd2, 6'd0}, 16'h0000, 1'b0, -1);
    end
    issue(16'hF000, 16'h0000, 1'b0, -1);
    issue(16'h0240, 16'h0000, 1'b0, -1);
    issue(16'h3240, 16'h0000, 1'b0, -1);

    issue(16'h4440, 16'h0000, 1'b0, 1);
    issue(16'h4440, 16'h0000, 1'b0, -1);
    idle();

    cycle(1'b1, 1'b1, 16'h1200, 1'b0, ZERO, "reset_with_run");
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, ZERO, "after_reset_with_run");
    issue(16'h1e00, 16'h1234, 1'b0, -1);

    for (int i = 0; i < 300; i++) begin
      abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1;
      issue(16'($urandom), 16'($urandom), 1'($urandom), abort_at);
      repeat ($urandom_range(0, 2)) idle();
    end
    idle();
    idle();

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(negedge Clock);
      wait_cnt++;
    end
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
